// File: rtl/uart_rx.sv
// 8N1 UART receiver with a small receive FIFO and a peripheral-bus register interface.
// Bit timing is DIV clocks per bit, sampled at mid-bit after a two-flop synchroniser.
module uart_rx #(
    parameter int DIV   = 104,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] addr,
    input  logic       ren,
    output logic [7:0] rdata,
    output logic       rd_valid,
    input  logic       wen,
    input  logic [7:0] wdata,
    input  logic       rx
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [15:0]     HALF_LAST = 16'(DIV / 2 - 1);
    localparam logic [15:0]     BIT_LAST  = 16'(DIV - 1);
    localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [15:0]   r_divCnt;
    logic [15:0]   w_nextDiv;
    logic [2:0]    r_bitCnt;
    logic [2:0]    w_nextBit;
    logic [7:0]    r_shift;
    logic [7:0]    w_nextShift;
    logic          w_push;
    logic          w_frameErr;

    logic          r_rxMeta;
    logic          r_rxS;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_ovr;
    logic          r_ferr;

    logic          w_full;
    logic          w_notEmpty;
    logic          w_pop;
    logic          w_accept;
    logic          w_statusWr;
    logic [7:0]    w_readData;
    logic          w_unusedWdata;

    assign w_full        = (r_count == FULL_CNT);
    assign w_notEmpty    = (r_count != '0);
    assign w_pop         = ren && (addr == 3'd0) && w_notEmpty;
    assign w_accept      = w_push && (!w_full || w_pop);
    assign w_statusWr    = wen && !ren && (addr == 3'd1);
    assign w_unusedWdata = ^{wdata[7:3], wdata[0]};

    // rx is asynchronous to clk; the synchroniser idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxMeta <= 1'b1;
            r_rxS    <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxS    <= r_rxMeta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_divCnt <= '0;
            r_bitCnt <= '0;
            r_shift  <= '0;
        end else begin
            r_state  <= w_nextState;
            r_divCnt <= w_nextDiv;
            r_bitCnt <= w_nextBit;
            r_shift  <= w_nextShift;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextDiv   = r_divCnt;
        w_nextBit   = r_bitCnt;
        w_nextShift = r_shift;
        w_push      = 1'b0;
        w_frameErr  = 1'b0;
        case (r_state)
            IDLE: begin
                w_nextDiv = '0;
                if (!r_rxS) w_nextState = START;
            end
            START: begin
                if (r_divCnt == HALF_LAST) begin
                    w_nextDiv   = '0;
                    w_nextBit   = '0;
                    w_nextState = r_rxS ? IDLE : DATA;
                end else begin
                    w_nextDiv = r_divCnt + 16'd1;
                end
            end
            DATA: begin
                if (r_divCnt == BIT_LAST) begin
                    w_nextDiv   = '0;
                    w_nextShift = {r_rxS, r_shift[7:1]};
                    if (r_bitCnt == 3'd7) w_nextState = STOP;
                    else                  w_nextBit   = r_bitCnt + 3'd1;
                end else begin
                    w_nextDiv = r_divCnt + 16'd1;
                end
            end
            STOP: begin
                if (r_divCnt == BIT_LAST) begin
                    w_nextDiv = '0;
                    if (r_rxS) begin
                        w_push      = 1'b1;
                        w_nextState = IDLE;
                    end else begin
                        w_frameErr  = 1'b1;
                        w_nextState = WAIT_IDLE;
                    end
                end else begin
                    w_nextDiv = r_divCnt + 16'd1;
                end
            end
            WAIT_IDLE: begin
                w_nextDiv = '0;
                if (r_rxS) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Storage needs no reset: emptiness is tracked entirely by the pointers and count
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wrPtr] <= r_shift;
    end

    // A pop in the same cycle as a push to a full FIFO frees the slot the push then uses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)    r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Setting a sticky flag takes priority over a software clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop)    r_ovr <= 1'b1;
            else if (w_statusWr && wdata[1])   r_ovr <= 1'b0;
            if (w_frameErr)                    r_ferr <= 1'b1;
            else if (w_statusWr && wdata[2])   r_ferr <= 1'b0;
        end
    end

    always_comb begin
        w_readData = 8'h00;
        case (addr)
            3'd0:    if (w_notEmpty) w_readData = r_mem[r_rdPtr];
            3'd1:    w_readData = {4'b0000, w_full, r_ferr, r_ovr, w_notEmpty};
            default: w_readData = 8'h00;
        endcase
    end

    // rdata is forced to zero outside the acknowledge cycle because the bus ORs all peripherals
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata    <= 8'h00;
            rd_valid <= 1'b0;
        end else if (ren) begin
            rdata    <= w_readData;
            rd_valid <= 1'b1;
        end else begin
            rdata    <= 8'h00;
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven on rx and results read back over
// the bus, compared against a queue-based model of the receive FIFO and its sticky flags.
module tb_uart_rx;

    localparam int DIV   = 16;
    localparam int DEPTH = 4;
    // Negedge index (from the start-bit fall) whose bus op lands on the stop-bit sampling edge:
    // two synchroniser flops, one detect cycle, half a bit, then nine full bits.
    localparam int STOP_EDGE_OP = 2 + DIV / 2 + 9 * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] addr;
    logic       ren;
    logic [7:0] rdata;
    logic       rd_valid;
    logic       wen;
    logic [7:0] wdata;
    logic       rx;

    int checks   = 0;
    int failures = 0;

    logic [7:0] modelQ[$];
    logic       modelOvr;
    logic       modelFerr;

    uart_rx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .ren      (ren),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .wen      (wen),
        .wdata    (wdata),
        .rx       (rx)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] expStatus();
        return {4'b0000, (modelQ.size() == DEPTH), modelFerr, modelOvr, (modelQ.size() != 0)};
    endfunction

    function automatic void modelPush(input logic [7:0] b);
        if (modelQ.size() < DEPTH) modelQ.push_back(b);
        else                       modelOvr = 1'b1;
    endfunction

    function automatic logic [7:0] modelPop();
        if (modelQ.size() == 0) return 8'h00;
        return modelQ.pop_front();
    endfunction

    function automatic logic frameBit(input logic [7:0] d, input logic stopBit, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return stopBit;
        return d[idx-1];
    endfunction

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic busRead(input logic [2:0] a, output logic [7:0] d, output logic v,
                           output logic vAfter);
        @(negedge clk);
        addr = a;
        ren  = 1'b1;
        @(negedge clk);
        d    = rdata;
        v    = rd_valid;
        ren  = 1'b0;
        @(negedge clk);
        vAfter = rd_valid;
    endtask

    task automatic busWrite(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        @(negedge clk);
        wen   = 1'b0;
    endtask

    // Drives one full frame; optionally issues a bus op on negedge index opAt of the frame
    task automatic sendFrameOp(input logic [7:0] data, input logic stopBit, input int opAt,
                               input logic opWrite, input logic [2:0] opAddr,
                               input logic [7:0] opData, output logic [7:0] opRdata,
                               output logic opValid);
        opRdata = 8'h00;
        opValid = 1'b0;
        for (int i = 0; i < 10 * DIV; i++) begin
            @(negedge clk);
            if (opAt >= 0 && i == opAt + 1) begin
                opRdata = rdata;
                opValid = rd_valid;
                ren     = 1'b0;
                wen     = 1'b0;
            end
            rx = frameBit(data, stopBit, i / DIV);
            if (i == opAt) begin
                addr = opAddr;
                if (opWrite) begin
                    wdata = opData;
                    wen   = 1'b1;
                end else begin
                    ren = 1'b1;
                end
            end
        end
    endtask

    task automatic sendFrame(input logic [7:0] data);
        logic [7:0] d;
        logic       v;
        sendFrameOp(data, 1'b1, -1, 1'b0, 3'd0, 8'h00, d, v);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       v, va;
        rst_n = 1'b0; rx = 1'b1; ren = 1'b0; wen = 1'b0; addr = 3'd0; wdata = 8'h00;
        modelQ.delete(); modelOvr = 1'b0; modelFerr = 1'b0;
        idleCycles(3);
        if (rdata !== 8'h00) begin failures++; $display("[TB] FAIL reset_rdata: got %02h expected 00", rdata); end
        checks++;
        if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++;
        rst_n = 1'b1;
        idleCycles(3);
        if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_rd_valid: got %b expected 0", rd_valid); end
        checks++;
        busRead(3'd1, d, v, va);
        if (d !== 8'h00) begin failures++; $display("[TB] FAIL reset_status: got %02h expected 00", d); end
        checks++;
        if (v !== 1'b1 || va !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid_pulse: got %b%b expected 10", v, va); end
        checks++;
    endtask

    task automatic test_single_byte();
        logic [7:0] d, exp, b;
        logic       v, va;
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            sendFrame(b);
            modelPush(b);
            idleCycles(2);
            busRead(3'd1, d, v, va);
            exp = expStatus();
            if (d !== exp) begin failures++; $display("[TB] FAIL single_status_full: got %02h expected %02h", d, exp); end
            checks++;
            busRead(3'd0, d, v, va);
            exp = modelPop();
            if (d !== exp || v !== 1'b1) begin failures++; $display("[TB] FAIL single_data: got %02h/%b expected %02h/1", d, v, exp); end
            checks++;
            busRead(3'd1, d, v, va);
            exp = expStatus();
            if (d !== exp) begin failures++; $display("[TB] FAIL single_status_empty: got %02h expected %02h", d, exp); end
            checks++;
        end
    endtask

    task automatic test_reg_map();
        logic [7:0] d, exp, b;
        logic       v, va;
        b = 8'($urandom_range(1, 255));
        sendFrame(b);
        modelPush(b);
        busWrite(3'd0, ~b);
        busWrite(3'd3, 8'hFF);
        for (int a = 2; a < 8; a++) begin
            busRead(3'(a), d, v, va);
            if (d !== 8'h00 || v !== 1'b1) begin failures++; $display("[TB] FAIL unmapped_read_%0d: got %02h/%b expected 00/1", a, d, v); end
            checks++;
        end
        busRead(3'd1, d, v, va);
        exp = expStatus();
        if (d !== exp) begin failures++; $display("[TB] FAIL regmap_status: got %02h expected %02h", d, exp); end
        checks++;
        busRead(3'd0, d, v, va);
        exp = modelPop();
        if (d !== exp) begin failures++; $display("[TB] FAIL regmap_data: got %02h expected %02h", d, exp); end
        checks++;
    endtask

    task automatic test_overrun();
        logic [7:0] d, exp;
        logic       v, va;
        logic [7:0] bytes [5];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        foreach (bytes[k]) begin
            sendFrame(bytes[k]);
            modelPush(bytes[k]);
        end
        busRead(3'd1, d, v, va);
        exp = expStatus();
        if (d !== exp) begin failures++; $display("[TB] FAIL overrun_status: got %02h expected %02h", d, exp); end
        checks++;
        @(negedge clk);
        addr = 3'd1; ren = 1'b1; wen = 1'b1; wdata = 8'h06;
        @(negedge clk);
        d = rdata;
        ren = 1'b0; wen = 1'b0;
        if (d !== exp) begin failures++; $display("[TB] FAIL ren_wen_read: got %02h expected %02h", d, exp); end
        checks++;
        busRead(3'd1, d, v, va);
        if (d !== exp) begin failures++; $display("[TB] FAIL ren_wen_write_dropped: got %02h expected %02h", d, exp); end
        checks++;
        for (int k = 0; k < 5; k++) begin
            busRead(3'd0, d, v, va);
            exp = modelPop();
            if (d !== exp) begin failures++; $display("[TB] FAIL overrun_data_%0d: got %02h expected %02h", k, d, exp); end
            checks++;
        end
        busWrite(3'd1, 8'h02);
        modelOvr = 1'b0;
        busRead(3'd1, d, v, va);
        exp = expStatus();
        if (d !== exp) begin failures++; $display("[TB] FAIL ovr_clear: got %02h expected %02h", d, exp); end
        checks++;
    endtask

    task automatic test_framing_error();
        logic [7:0] d, exp;
        logic       v, va;
        // Clearing ferr on the very edge it is set must leave it set
        sendFrameOp(8'($urandom_range(0, 255)), 1'b0, STOP_EDGE_OP, 1'b1, 3'd1, 8'h04, d, v);
        modelFerr = 1'b1;
        idleCycles(5 * DIV);
        rx = 1'b1;
        idleCycles(2 * DIV);
        busRead(3'd1, d, v, va);
        exp = expStatus();
        if (d !== exp) begin failures++; $display("[TB] FAIL ferr_status: got %02h expected %02h", d, exp); end
        checks++;
        sendFrame(8'h3C);
        modelPush(8'h3C);
        busRead(3'd0, d, v, va);
        exp = modelPop();
        if (d !== exp) begin failures++; $display("[TB] FAIL ferr_recovery_data: got %02h expected %02h", d, exp); end
        checks++;
        busWrite(3'd1, 8'h04);
        modelFerr = 1'b0;
        busRead(3'd1, d, v, va);
        exp = expStatus();
        if (d !== exp) begin failures++; $display("[TB] FAIL ferr_clear: got %02h expected %02h", d, exp); end
        checks++;
    endtask

    task automatic test_glitch_and_reset();
        logic [7:0] d, exp, b;
        logic       v, va;
        rx = 1'b0;
        idleCycles(DIV / 4);
        rx = 1'b1;
        idleCycles(2 * DIV);
        busRead(3'd1, d, v, va);
        exp = expStatus();
        if (d !== exp) begin failures++; $display("[TB] FAIL glitch_status: got %02h expected %02h", d, exp); end
        checks++;
        b = 8'($urandom_range(0, 255));
        for (int i = 0; i < 5 * DIV; i++) begin
            @(negedge clk);
            rx = frameBit(b, 1'b1, i / DIV);
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        modelQ.delete(); modelOvr = 1'b0; modelFerr = 1'b0;
        idleCycles(2);
        rst_n = 1'b1;
        idleCycles(2 * DIV);
        busRead(3'd1, d, v, va);
        exp = expStatus();
        if (d !== exp) begin failures++; $display("[TB] FAIL midframe_reset_status: got %02h expected %02h", d, exp); end
        checks++;
        b = 8'($urandom_range(0, 255));
        sendFrame(b);
        modelPush(b);
        busRead(3'd0, d, v, va);
        exp = modelPop();
        if (d !== exp) begin failures++; $display("[TB] FAIL post_reset_data: got %02h expected %02h", d, exp); end
        checks++;
    endtask

    task automatic test_full_pop_push();
        logic [7:0] d, exp, b;
        logic       v, va;
        // Empty FIFO: a DATA read on the push edge returns 0 and the byte stays queued
        b = 8'($urandom_range(0, 255));
        sendFrameOp(b, 1'b1, STOP_EDGE_OP, 1'b0, 3'd0, 8'h00, d, v);
        exp = modelPop();
        modelPush(b);
        if (d !== exp || v !== 1'b1) begin failures++; $display("[TB] FAIL empty_pop_push_read: got %02h/%b expected %02h/1", d, v, exp); end
        checks++;
        busRead(3'd0, d, v, va);
        exp = modelPop();
        if (d !== exp) begin failures++; $display("[TB] FAIL empty_pop_push_data: got %02h expected %02h", d, exp); end
        checks++;
        for (int k = 0; k < DEPTH; k++) begin
            b = 8'($urandom_range(0, 255));
            sendFrame(b);
            modelPush(b);
        end
        b = 8'($urandom_range(0, 255));
        sendFrameOp(b, 1'b1, STOP_EDGE_OP, 1'b0, 3'd0, 8'h00, d, v);
        exp = modelPop();
        modelPush(b);
        if (d !== exp || v !== 1'b1) begin failures++; $display("[TB] FAIL full_pop_push_read: got %02h/%b expected %02h/1", d, v, exp); end
        checks++;
        busRead(3'd1, d, v, va);
        exp = expStatus();
        if (d !== exp) begin failures++; $display("[TB] FAIL full_pop_push_status: got %02h expected %02h", d, exp); end
        checks++;
        for (int k = 0; k < DEPTH; k++) begin
            busRead(3'd0, d, v, va);
            exp = modelPop();
            if (d !== exp) begin failures++; $display("[TB] FAIL full_pop_push_data_%0d: got %02h expected %02h", k, d, exp); end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, exp, b;
        logic       v, va;
        sendFrame(8'h00);
        modelPush(8'h00);
        sendFrame(8'hFF);
        modelPush(8'hFF);
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom_range(0, 255));
            sendFrame(b);
            modelPush(b);
        end
        busRead(3'd1, d, v, va);
        exp = expStatus();
        if (d !== exp) begin failures++; $display("[TB] FAIL b2b_status: got %02h expected %02h", d, exp); end
        checks++;
        for (int k = 0; k < DEPTH + 1; k++) begin
            busRead(3'd0, d, v, va);
            exp = modelPop();
            if (d !== exp) begin failures++; $display("[TB] FAIL b2b_data_%0d: got %02h expected %02h", k, d, exp); end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_reg_map();
        test_overrun();
        test_framing_error();
        test_glitch_and_reset();
        test_full_pop_push();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
